// File: rtl/ahb_lite_reg_bridge.sv
// AHB5-Lite slave that turns single AHB transfers into req/ack register-bus accesses.
// It inserts wait states until the register side acks, and it has an ack timeout and a two-cycle ERROR response.
module ahb_lite_reg_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [31:0]       hwdata,
  input  logic              hreadyin,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              reg_req,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_wstrb,
  input  logic              reg_ack,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_OKAY,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             unsupported;
  logic [3:0]       strobe;
  logic             unused_inputs;

  function automatic logic is_unsupported(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000:  return 4'b0001 << a;
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // hreadyout is low in ACCESS and ERR1, so a new address phase can only land in IDLE/OKAY/ERR2.
  assign accept      = hsel & htrans[1] & hreadyin & hreadyout;
  assign unsupported = is_unsupported(hsize, haddr[1:0]);
  assign strobe      = hwrite ? byte_strobe(hsize, haddr[1:0]) : 4'b0000;
  assign reg_wdata   = reg_req ? hwdata : 32'h0;

  // Burst type, protection, and the BUSY/SEQ distinction do not change how a beat is handled.
  assign unused_inputs = ^{hburst, hprot, htrans[0], haddr};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= 32'h0;
      reg_req   <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wstrb <= 4'b0000;
    end else begin
      case (state)
        S_IDLE, S_OKAY, S_ERR2: begin
          if (accept) begin
            reg_addr  <= {haddr[ADDR_W-1:2], 2'b00};
            reg_wr    <= hwrite;
            hreadyout <= 1'b0;
            if (unsupported) begin
              state   <= S_ERR1;
              hresp   <= 1'b1;
              reg_req <= 1'b0;
            end else begin
              state     <= S_ACCESS;
              hresp     <= 1'b0;
              reg_req   <= 1'b1;
              reg_wstrb <= strobe;
              wait_cnt  <= '0;
            end
          end else begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end

        // An ack in the expiry cycle is checked first, so it wins over the timeout.
        S_ACCESS: begin
          if (reg_ack) begin
            reg_req <= 1'b0;
            if (reg_err) begin
              state <= S_ERR1;
              hresp <= 1'b1;
            end else begin
              state     <= S_OKAY;
              hreadyout <= 1'b1;
              hresp     <= 1'b0;
              if (!reg_wr) hrdata <= reg_rdata;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state   <= S_ERR1;
            reg_req <= 1'b0;
            hresp   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_ERR1: begin
          state     <= S_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          reg_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_reg_bridge.sv
// Bench for ahb_lite_reg_bridge: a transaction-level model is checked every cycle,
// and directed transfers are pinned with hand-computed values.
module tb_ahb_lite_reg_bridge;

  localparam int TIMEOUT = 16;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hreadyin;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        reg_req;
  logic        reg_wr;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic        reg_err;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  ahb_lite_reg_bridge #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hreadyin(hreadyin), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passes++;
  endtask

  // Transaction-level model: one outstanding access plus a countdown of ERROR cycles.
  logic        m_busy;
  int          m_cnt;
  int          m_err;
  logic [31:0] m_rdata;
  logic [31:0] m_addr;
  logic        m_wr;
  logic [3:0]  m_strb;
  logic [31:0] m_nbytes;
  logic        m_bad;
  logic [3:0]  m_strb_nx;
  logic        exp_ready;
  logic        exp_resp;

  always_comb begin
    m_nbytes  = 32'd1 << hsize;
    m_bad     = (hsize > 3'd2) || ((haddr % m_nbytes) != 32'd0);
    m_strb_nx = 4'b0000;
    if (hwrite) m_strb_nx = 4'(((32'd1 << m_nbytes) - 32'd1) << haddr[1:0]);
  end

  assign exp_ready = !m_busy && (m_err != 2);
  assign exp_resp  = (m_err != 0);

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      m_busy <= 1'b0; m_cnt <= 0; m_err <= 0; m_rdata <= 32'h0;
      m_addr <= 32'h0; m_wr <= 1'b0; m_strb <= 4'h0;
    end else if (m_busy) begin
      if (reg_ack) begin
        m_busy <= 1'b0;
        m_err  <= reg_err ? 2 : 0;
        if (!reg_err && !m_wr) m_rdata <= reg_rdata;
      end else if (m_cnt + 1 >= TIMEOUT) begin
        m_busy <= 1'b0;
        m_err  <= 2;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (m_err == 2) begin
      m_err <= 1;
    end else if (hsel && htrans[1] && hreadyin) begin
      if (m_bad) begin
        m_err <= 2;
      end else begin
        m_busy <= 1'b1; m_cnt <= 0; m_err <= 0;
        m_addr <= haddr & ~32'd3; m_wr <= hwrite; m_strb <= m_strb_nx;
      end
    end else begin
      m_err <= 0;
    end
  end

  always @(posedge hclk) begin
    #1;
    if (cmp_en) begin
      chk("cyc_hreadyout", 32'(hreadyout), 32'(exp_ready));
      chk("cyc_hresp", 32'(hresp), 32'(exp_resp));
      chk("cyc_reg_req", 32'(reg_req), 32'(m_busy));
      chk("cyc_hrdata", hrdata, m_rdata);
      if (m_busy) begin
        chk("cyc_reg_addr", reg_addr, m_addr);
        chk("cyc_reg_wr", 32'(reg_wr), 32'(m_wr));
        chk("cyc_reg_wstrb", 32'(reg_wstrb), 32'(m_strb));
        chk("cyc_reg_wdata", reg_wdata, hwdata);
      end
    end
  end

  int          ws, last_ws;
  logic        last_resp;
  logic        snap_req, snap_ready, snap_resp;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_strb, snap_mstrb;

  // One transfer; the ack is pulsed in the dly-th ACCESS cycle (dly=0: never).
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input int dly, input logic [31:0] rd,
                      input logic er);
    int cyc;
    bit done;
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    cyc = 1; done = 1'b0; ws = 0;
    while (cyc <= 40 && !done) begin
      if (dly != 0 && cyc == dly) begin
        reg_ack = 1'b1; reg_rdata = rd; reg_err = er;
      end else begin
        reg_ack = 1'b0;
      end
      #1;
      if (cyc == 1) begin
        snap_req = reg_req; snap_ready = hreadyout; snap_resp = hresp;
        snap_addr = reg_addr; snap_wdata = reg_wdata; snap_strb = reg_wstrb;
        snap_mstrb = m_strb;
      end
      if (hreadyout) begin
        done = 1'b1;
        last_resp = hresp;
      end else begin
        ws++;
        @(negedge hclk);
        cyc++;
      end
    end
    reg_ack = 1'b0;
    if (!done) chk("xfer_completes", 32'd0, 32'd1);
    last_ws = ws;
  endtask

  logic [31:0] t_addr [5] = '{32'h42, 32'h41, 32'h52, 32'h50, 32'h60};
  logic [2:0]  t_size [5] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
  logic [3:0]  t_strb [5] = '{4'b0100, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
  logic [31:0] u_addr [4] = '{32'h43, 32'h62, 32'h60, 32'h60};
  logic [2:0]  u_size [4] = '{3'd1, 3'd2, 3'd3, 3'd4};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    hresetn = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = 32'h0; hreadyin = 1'b1;
    reg_ack = 1'b0; reg_rdata = 32'h0; reg_err = 1'b0;
    repeat (2) @(negedge hclk);
    #1;
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_reg_req", 32'(reg_req), 32'd0);
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_reg_addr", reg_addr, 32'h0);
    chk("rst_reg_wstrb", 32'(reg_wstrb), 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    cmp_en = 1'b1;

    xfer(32'h40, 1'b1, 3'd2, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    chk("ww_req", 32'(snap_req), 32'd1);
    chk("ww_addr", snap_addr, 32'h40);
    chk("ww_strb", 32'(snap_strb), 32'hF);
    chk("ww_wdata", snap_wdata, 32'hDEADBEEF);
    chk("ww_waits", 32'(last_ws), 32'd2);
    chk("ww_resp", 32'(last_resp), 32'd0);

    xfer(32'h43, 1'b0, 3'd0, 32'h0, 1, 32'hAA000000, 1'b0);
    chk("br_strb", 32'(snap_strb), 32'h0);
    chk("br_addr", snap_addr, 32'h40);
    chk("br_waits", 32'(last_ws), 32'd1);
    chk("br_hrdata", hrdata, 32'hAA000000);

    for (int i = 0; i < 5; i++) begin
      xfer(t_addr[i], 1'b1, t_size[i], 32'h01020304 + i, 1, 32'h0, 1'b0);
      chk("tbl_strb", 32'(snap_strb), 32'(t_strb[i]));
      chk("tbl_model_strb", 32'(snap_mstrb), 32'(t_strb[i]));
      chk("tbl_addr", snap_addr, t_addr[i] & ~32'd3);
    end

    for (int i = 0; i < 4; i++) begin
      xfer(u_addr[i], 1'b1, u_size[i], 32'h0, 1, 32'h0, 1'b0);
      chk("uns_req", 32'(snap_req), 32'd0);
      chk("uns_err1", {30'd0, snap_ready, snap_resp}, 32'd1);
      chk("uns_err2", 32'(last_resp), 32'd1);
      chk("uns_waits", 32'(last_ws), 32'd1);
    end

    xfer(32'h80, 1'b0, 3'd2, 32'h0, 0, 32'h0, 1'b0);
    chk("to_waits", 32'(last_ws), 32'(TIMEOUT + 1));
    chk("to_resp", 32'(last_resp), 32'd1);
    @(negedge hclk);
    reg_ack = 1'b1; reg_rdata = 32'h12345678;
    @(negedge hclk);
    reg_ack = 1'b0;
    #1;
    chk("late_ack_hrdata", hrdata, 32'hAA000000);
    chk("late_ack_ready", 32'(hreadyout), 32'd1);

    xfer(32'h44, 1'b0, 3'd2, 32'h0, 3, 32'hFFFFFFFF, 1'b1);
    chk("rerr_waits", 32'(last_ws), 32'd4);
    chk("rerr_resp", 32'(last_resp), 32'd1);
    chk("rerr_hrdata", hrdata, 32'hAA000000);

    xfer(32'h88, 1'b0, 3'd2, 32'h0, TIMEOUT, 32'h5A5A0001, 1'b0);
    chk("edge_ack_resp", 32'(last_resp), 32'd0);
    chk("edge_ack_waits", 32'(last_ws), 32'(TIMEOUT));
    chk("edge_ack_hrdata", hrdata, 32'h5A5A0001);

    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h90; hwrite = 1'b1; hsize = 3'd2; hreadyin = 1'b0;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hreadyin = 1'b1;
    #1;
    chk("nohready_req", 32'(reg_req), 32'd0);
    chk("nohready_ready", 32'(hreadyout), 32'd1);

    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
    @(negedge hclk);
    haddr = 32'h4; hwdata = 32'h11111111; reg_ack = 1'b1;
    #1;
    chk("b2b_req1", 32'(reg_req), 32'd1);
    chk("b2b_addr1", reg_addr, 32'h0);
    @(negedge hclk);
    reg_ack = 1'b0;
    #1;
    chk("b2b_okay_ready", 32'(hreadyout), 32'd1);
    chk("b2b_okay_req", 32'(reg_req), 32'd0);
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h22222222; reg_ack = 1'b1;
    #1;
    chk("b2b_req2", 32'(reg_req), 32'd1);
    chk("b2b_addr2", reg_addr, 32'h4);
    chk("b2b_wdata2", reg_wdata, 32'h22222222);
    @(negedge hclk);
    reg_ack = 1'b0;
    #1;
    chk("b2b_done", {30'd0, hreadyout, hresp}, 32'd2);

    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00;
    #1;
    chk("arst_pre_req", 32'(reg_req), 32'd1);
    #2;
    hresetn = 1'b0;
    #1;
    chk("arst_req", 32'(reg_req), 32'd0);
    chk("arst_ready", 32'(hreadyout), 32'd1);
    chk("arst_resp", 32'(hresp), 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    repeat (3) @(negedge hclk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
